mult_dot_accumulator: RTL and testbench

- Downstream stage of the pipelined array multiplier.
- Consumes one product per cycle from the multiplier's fixed-latency output and sums groups of products (dot products) delimited by a last flag.
- The multiplier has no valid or stall path, so this block carries a valid/last tag delay line matched to the multiplier latency.
- Presents each finished sum through a one-entry valid/ready output buffer.

---
 rtl/mult_dot_accumulator.sv | 137 +++++++++++++
 tb/tb_mult_dot_accumulator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_dot_accumulator.sv
// mult_dot_accumulator
// Sits after the fixed-latency pipelined array multiplier. Each product is
// added into a running dot-product sum. A group of terms ends on a term
// tagged "last", and the finished sum and term count go into a one-entry
// result buffer.
// The multiplier carries no valid signal, so a {valid,last} tag line with
// the same latency runs alongside it.
// Optional feature: define MULT_ACC_SATURATE_EN to clamp the accumulator to
// all-ones on carry-out. When it is undefined the sum wraps modulo 2^ACC_W.
//
// Result handshake: a result transfers on any rising edge where
// res_valid & res_ready. res_data and res_count stay stable while
// res_valid & !res_ready. res_valid never waits on res_ready. The buffer
// counts as free on an edge where it is empty or being accepted, so a new
// result can load on the same edge that the old one leaves.
module mult_dot_accumulator #(
  parameter int WIDTH   = 64,
  parameter int LATENCY = WIDTH + 1,
  parameter int ACC_W   = 2*WIDTH + 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [2*WIDTH-1:0] product,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ACC_W-1:0]   res_data,
  output logic [CNT_W-1:0]   res_count,
  output logic               overflow,
  output logic               overrun,
  output logic               dbg_state
);

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t           state;
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_l;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;

  logic             al_v;
  logic             al_l;
  logic             buf_free;
  logic [ACC_W-1:0] base;
  logic [CNT_W-1:0] cnt_base;
  logic [ACC_W:0]   sum_full;
  logic             carry;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;

  // The final tag stage lines up with the product currently on the input.
  assign al_v      = tag_v[LATENCY];
  assign al_l      = tag_l[LATENCY];
  assign buf_free  = !res_valid || res_ready;
  assign dbg_state = state;

  // Tag delay line. It shifts every cycle, and a flush empties it so that
  // products still in flight are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v <= '0;
      tag_l <= '0;
    end else if (clear) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v <= {tag_v[LATENCY-1:0], in_valid};
      tag_l <= {tag_l[LATENCY-1:0], in_valid & in_last};
    end
  end

  // Next sum and count for the aligned term. IDLE starts from zero, so the
  // first term and a single-term group share the same adder.
  always_comb begin
    base     = (state == ACCUM) ? acc : '0;
    cnt_base = (state == ACCUM) ? cnt : '0;
    sum_full = {1'b0, base} + {1'b0, ACC_W'(product)};
    carry    = sum_full[ACC_W];
`ifdef MULT_ACC_SATURATE_EN
    sum      = carry ? '1 : sum_full[ACC_W-1:0];
`else
    sum      = sum_full[ACC_W-1:0];
`endif
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  // Group FSM, accumulator, result buffer and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_count <= '0;
      overflow  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (res_valid && res_ready)
        res_valid <= 1'b0;
      if (al_v) begin
        if (carry)
          overflow <= 1'b1;
        if (al_l) begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
          if (buf_free) begin
            res_valid <= 1'b1;
            res_data  <= sum;
            res_count <= cnt_next;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          state <= ACCUM;
          acc   <= sum;
          cnt   <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// Bench for mult_dot_accumulator with WIDTH=8, LATENCY=9, ACC_W=17.
// It models the upstream multiplier as a product delay line. The reference
// model works on whole groups: it sums each group arithmetically when the
// group is issued, then schedules each term's effect LATENCY+1 edges later.
module tb_mult_dot_accumulator;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 9;
  localparam int ACC_W   = 17;
  localparam int CNT_W   = 16;
  localparam longint MAXA = (64'd1 << ACC_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               clear = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_last = 1'b0;
  logic [WIDTH-1:0]   op_a = '0;
  logic [WIDTH-1:0]   op_b = '0;
  logic [2*WIDTH-1:0] product;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [ACC_W-1:0]   res_data;
  logic [CNT_W-1:0]   res_count;
  logic               overflow;
  logic               overrun;
  logic               dbg_state;

  logic [2*WIDTH-1:0] mp [0:LATENCY];

  // ---------------- clock / reset / upstream multiplier ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mp[0] <= op_a * op_b;
    for (int k = 1; k <= LATENCY; k++) mp[k] <= mp[k-1];
  end
  assign product = mp[LATENCY];

  mult_dot_accumulator #(
    .WIDTH(WIDTH), .LATENCY(LATENCY), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_last(in_last), .product(product),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count),
    .overflow(overflow), .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int     due;
    bit     carry;
    bit     last;
    longint sum;
    int     cnt;
  } ev_t;

  ev_t         ev_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] seen_q[$];
  longint      run_sum;
  int          run_cnt;
  int          ncyc = 0;
  bit          m_valid, m_ovf, m_ovr;
  longint      m_data;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    ev_q.delete();
    exp_q.delete();
    run_sum = 0;
    run_cnt = 0;
    m_valid = 0;
    m_data  = 0;
    m_cnt   = 0;
    m_ovf   = 0;
    m_ovr   = 0;
  endtask

  // Add one term to the group being issued and schedule when it takes effect.
  task automatic model_issue(input bit last, input longint p);
    ev_t    ev;
    longint full;
    full     = run_sum + p;
    ev.carry = (full > MAXA);
`ifdef MULT_ACC_SATURATE_EN
    run_sum  = ev.carry ? MAXA : full;
`else
    run_sum  = full % (MAXA + 1);
`endif
    run_cnt  = (run_cnt + 1 > 65535) ? 65535 : run_cnt + 1;
    ev.due   = ncyc + LATENCY + 1;
    ev.last  = last;
    ev.sum   = run_sum;
    ev.cnt   = run_cnt;
    ev_q.push_back(ev);
    if (last) begin
      run_sum = 0;
      run_cnt = 0;
    end
  endtask

  task automatic compare_outputs();
    chk("res_valid", 64'(res_valid), 64'(m_valid));
    chk("res_data",  64'(res_data),  64'(m_data));
    chk("res_count", 64'(res_count), 64'(m_cnt));
    chk("overflow",  64'(overflow),  64'(m_ovf));
    chk("overrun",   64'(overrun),   64'(m_ovr));
  endtask

  // ---------------- driver tasks ----------------
  // Called 1 time unit after an edge. Drives one cycle of inputs, advances
  // the model across the next edge, then compares.
  task automatic step(input bit v, input bit l, input int a, input int b,
                      input bit rdy, input bit clr);
    bit          acc_now;
    logic [63:0] cap;
    ev_t         ev;
    in_valid  = v;
    in_last   = l;
    op_a      = a[WIDTH-1:0];
    op_b      = b[WIDTH-1:0];
    res_ready = rdy;
    clear     = clr;
    acc_now   = res_valid && rdy && !clr;
    cap       = 64'({res_count, res_data});
    @(posedge clk);
    ncyc++;
    if (clr) begin
      model_clear();
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (ev_q.size() > 0 && ev_q[0].due == ncyc) begin
        ev = ev_q.pop_front();
        if (ev.carry) m_ovf = 1;
        if (ev.last) begin
          if (!m_valid) begin
            m_valid = 1;
            m_data  = ev.sum;
            m_cnt   = ev.cnt;
            exp_q.push_back(64'((longint'(ev.cnt) << ACC_W) | ev.sum));
          end else begin
            m_ovr = 1;
          end
        end
      end
      if (v) model_issue(l, longint'(a[WIDTH-1:0]) * longint'(b[WIDTH-1:0]));
      if (acc_now) begin
        seen_q.push_back(cap);
        if (exp_q.size() == 0) chk("accept_unexpected", 64'd1, 64'd0);
        else chk("accept_data", cap, exp_q.pop_front());
      end
    end
    #1;
    compare_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rdy, 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    compare_outputs();
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] res_word(input int cnt, input longint sum);
    return 64'((longint'(cnt) << ACC_W) | sum);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    model_clear();
    #3;
    compare_outputs();
    chk("rst_state", 64'(dbg_state), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single term 3*5: visible after edge e0+LATENCY+1 for one cycle.
    step(1, 1, 3, 5, 1, 0);
    idle(LATENCY, 1);
    chk("single_early", 64'(res_valid), 64'd0);
    idle(1, 1);
    chk("single_valid", 64'(res_valid), 64'd1);
    chk("single_data", 64'(res_data), 64'd15);
    chk("single_count", 64'(res_count), 64'd1);
    idle(1, 1);
    chk("single_1cycle", 64'(res_valid), 64'd0);

    // Three-term group followed at once by a single-term group.
    seen_q.delete();
    step(1, 0, 1, 2, 1, 0);
    step(1, 0, 3, 4, 1, 0);
    step(1, 1, 5, 6, 1, 0);
    step(1, 1, 7, 7, 1, 0);
    idle(LATENCY + 4, 1);
    chk("grp3_seen", 64'(seen_q.size()), 64'd2);
    if (seen_q.size() >= 2) begin
      chk("grp3_result", seen_q[0], res_word(3, 44));
      chk("grp1_result", seen_q[1], res_word(1, 49));
    end

    // Backpressure: the first result is held and the second is dropped.
    seen_q.delete();
    step(1, 1, 2, 2, 0, 0);
    step(1, 1, 4, 4, 0, 0);
    idle(LATENCY + 4, 0);
    chk("bp_valid", 64'(res_valid), 64'd1);
    chk("bp_data", 64'(res_data), 64'd4);
    chk("bp_overrun", 64'(overrun), 64'd1);
    idle(1, 1);
    chk("bp_drained", 64'(res_valid), 64'd0);
    chk("bp_seen", seen_q.size() > 0 ? seen_q[0] : 64'hdead, res_word(1, 4));

    // Overflow: three terms of 255*255 with a 17-bit accumulator.
    step(1, 0, 255, 255, 1, 0);
    step(1, 0, 255, 255, 1, 0);
    step(1, 1, 255, 255, 1, 0);
    idle(LATENCY + 1, 0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_count", 64'(res_count), 64'd3);
`ifdef MULT_ACC_SATURATE_EN
    chk("ovf_data", 64'(res_data), 64'd131071);
`else
    chk("ovf_data", 64'(res_data), 64'd64003);
`endif

    // Reset mid-group, then a fresh 6*7.
    step(1, 0, 9, 9, 1, 0);
    step(1, 1, 8, 8, 1, 0);
    idle(3, 1);
    pulse_reset();
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_ovr", 64'(overrun), 64'd0);
    idle(LATENCY + 3, 1);
    step(1, 1, 6, 7, 0, 0);
    idle(LATENCY + 1, 0);
    chk("rst_after_data", 64'(res_data), 64'd42);
    chk("rst_after_count", 64'(res_count), 64'd1);
    idle(1, 1);

    // Set both flags again, then clear while a group is in flight.
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    step(1, 0, 255, 255, 0, 0);
    step(1, 0, 255, 255, 0, 0);
    step(1, 1, 255, 255, 0, 0);
    idle(LATENCY + 2, 0);
    chk("pre_clr_flags", 64'({overflow, overrun}), 64'd3);
    step(1, 0, 9, 9, 1, 0);
    step(1, 1, 8, 8, 1, 0);
    idle(3, 1);
    step(1, 1, 3, 3, 1, 1);
    chk("clr_ovf", 64'(overflow), 64'd0);
    chk("clr_ovr", 64'(overrun), 64'd0);
    chk("clr_valid", 64'(res_valid), 64'd0);
    idle(LATENCY + 3, 1);
    step(1, 1, 6, 7, 0, 0);
    idle(LATENCY + 1, 0);
    chk("clr_after_data", 64'(res_data), 64'd42);
    chk("clr_after_count", 64'(res_count), 64'd1);
    idle(1, 1);

    // Random groups with random backpressure, idle gaps and rare clears.
    for (int g = 0; g < 400; g++) begin
      int len;
      bit big;
      len = $urandom_range(1, 5);
      big = ($urandom_range(0, 3) == 0);
      for (int t = 0; t < len; t++) begin
        int a, b;
        a = big ? $urandom_range(200, 255) : $urandom_range(0, 255);
        b = big ? $urandom_range(200, 255) : $urandom_range(0, 255);
        step(1, t == len - 1, a, b, $urandom_range(0, 9) < 7,
             $urandom_range(0, 150) == 0);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), $urandom_range(0, 1));
    end
    idle(LATENCY + 6, 1);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
